// File: rtl/cc_goalregister_pkg.sv
// Shared types and defaults for the Frogger row-7 goal register.
package cc_goalregister_pkg;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_HOLD   = 2'd1,
        ST_CLEAR  = 2'd2
    } gr_state_e;

    localparam int DATAWIDTH_BUS_DEF = 8;
    localparam int HOLD_TICKS_DEF    = 4;
    localparam int LEVEL_WIDTH_DEF   = 4;

    // A one-tick hold still needs a 1-bit counter to hold the value 0.
    function automatic int hold_cnt_w(input int ticks);
        return ($clog2(ticks) < 1) ? 1 : $clog2(ticks);
    endfunction

endpackage

// File: rtl/cc_goalholdtimer.sv
// Frame-tick hold counter: load, decrement on tick, flag when at zero.
module cc_goalholdtimer
    import cc_goalregister_pkg::*;
#(
    parameter int HOLD_TICKS = HOLD_TICKS_DEF,
    parameter int CNT_W      = hold_cnt_w(HOLD_TICKS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             tick,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD_TICKS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (load)
            cnt <= LOAD_VAL;
        else if (tick && !zero)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/cc_goalregister.sv
// Row-7 home-slot register: tracks occupied slots, holds a won row for a
// number of frame ticks, then clears it and advances the level.
module cc_goalregister
    import cc_goalregister_pkg::*;
#(
    parameter int DATAWIDTH_BUS = DATAWIDTH_BUS_DEF,
    parameter int HOLD_TICKS    = HOLD_TICKS_DEF,
    parameter int LEVEL_WIDTH   = LEVEL_WIDTH_DEF
) (
    input  logic                     CC_GOALREGISTER_CLOCK_50,
    input  logic                     CC_GOALREGISTER_RESET_InLow,
    input  logic                     CC_GOALREGISTER_FrogArrive_In,
    input  logic [2:0]               CC_GOALREGISTER_FrogCol_In,
    input  logic                     CC_GOALREGISTER_FrameTick_In,
    input  logic                     CC_GOALREGISTER_WinL_In,
    input  logic                     CC_GOALREGISTER_Clear_In,
    output logic [DATAWIDTH_BUS-1:0] CC_GOALREGISTER_Data_Out,
    output logic                     CC_GOALREGISTER_FrogHome_Out,
    output logic                     CC_GOALREGISTER_FrogCrash_Out,
    output logic                     CC_GOALREGISTER_LevelUp_Out,
    output logic [LEVEL_WIDTH-1:0]   CC_GOALREGISTER_Level_Out,
    output logic                     CC_GOALREGISTER_Busy_Out
);

    localparam int CNT_W = hold_cnt_w(HOLD_TICKS);

    gr_state_e                state_q, state_nxt;
    logic [DATAWIDTH_BUS-1:0] data_q, data_nxt;
    logic [LEVEL_WIDTH-1:0]   level_q, level_nxt;
    logic                     home_q, home_nxt;
    logic                     crash_q, crash_nxt;
    logic                     lvlup_q, lvlup_nxt;
    logic                     busy_q;
    logic                     hold_load;
    logic                     hold_zero;
    logic [CNT_W-1:0]         hold_cnt;

    cc_goalholdtimer #(
        .HOLD_TICKS (HOLD_TICKS),
        .CNT_W      (CNT_W)
    ) u_holdtimer (
        .clk   (CC_GOALREGISTER_CLOCK_50),
        .rst_n (CC_GOALREGISTER_RESET_InLow),
        .clr   (CC_GOALREGISTER_Clear_In),
        .load  (hold_load),
        .tick  (CC_GOALREGISTER_FrameTick_In && (state_q == ST_HOLD)),
        .cnt   (hold_cnt),
        .zero  (hold_zero)
    );

    always_comb begin
        state_nxt = state_q;
        data_nxt  = data_q;
        level_nxt = level_q;
        home_nxt  = 1'b0;
        crash_nxt = 1'b0;
        lvlup_nxt = 1'b0;
        hold_load = 1'b0;
        if (CC_GOALREGISTER_Clear_In) begin
            state_nxt = ST_ACCEPT;
            data_nxt  = '0;
            level_nxt = '0;
        end else begin
            case (state_q)
                ST_ACCEPT: begin
                    // A win outranks an arrival landing in the same cycle.
                    if (CC_GOALREGISTER_WinL_In) begin
                        state_nxt = ST_HOLD;
                        hold_load = 1'b1;
                    end else if (CC_GOALREGISTER_FrogArrive_In) begin
                        if (!data_q[CC_GOALREGISTER_FrogCol_In]) begin
                            data_nxt[CC_GOALREGISTER_FrogCol_In] = 1'b1;
                            home_nxt = 1'b1;
                        end else begin
                            crash_nxt = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (CC_GOALREGISTER_FrameTick_In && hold_zero)
                        state_nxt = ST_CLEAR;
                end
                ST_CLEAR: begin
                    data_nxt  = '0;
                    lvlup_nxt = 1'b1;
                    level_nxt = (&level_q) ? level_q : level_q + 1'b1;
                    state_nxt = ST_ACCEPT;
                end
                default: state_nxt = ST_ACCEPT;
            endcase
        end
    end

    always_ff @(posedge CC_GOALREGISTER_CLOCK_50 or negedge CC_GOALREGISTER_RESET_InLow) begin
        if (!CC_GOALREGISTER_RESET_InLow) begin
            state_q <= ST_ACCEPT;
            data_q  <= '0;
            level_q <= '0;
            home_q  <= 1'b0;
            crash_q <= 1'b0;
            lvlup_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            data_q  <= data_nxt;
            level_q <= level_nxt;
            home_q  <= home_nxt;
            crash_q <= crash_nxt;
            lvlup_q <= lvlup_nxt;
            busy_q  <= (state_nxt != ST_ACCEPT);
        end
    end

    assign CC_GOALREGISTER_Data_Out      = data_q;
    assign CC_GOALREGISTER_FrogHome_Out  = home_q;
    assign CC_GOALREGISTER_FrogCrash_Out = crash_q;
    assign CC_GOALREGISTER_LevelUp_Out   = lvlup_q;
    assign CC_GOALREGISTER_Level_Out     = level_q;
    assign CC_GOALREGISTER_Busy_Out      = busy_q;

endmodule

// File: tb/tb_cc_goalregister.sv
// Directed bench for cc_goalregister with a combinational win-comparator model.
module tb_cc_goalregister;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       arrive = 1'b0;
    logic [2:0] col = 3'd0;
    logic       tick = 1'b0;
    logic       win;
    logic       clear = 1'b0;
    logic [7:0] data;
    logic       home, crash, lvlup, busy;
    logic [3:0] level;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign win = (data == 8'hFF);

    cc_goalregister dut (
        .CC_GOALREGISTER_CLOCK_50      (clk),
        .CC_GOALREGISTER_RESET_InLow   (rst_n),
        .CC_GOALREGISTER_FrogArrive_In (arrive),
        .CC_GOALREGISTER_FrogCol_In    (col),
        .CC_GOALREGISTER_FrameTick_In  (tick),
        .CC_GOALREGISTER_WinL_In       (win),
        .CC_GOALREGISTER_Clear_In      (clear),
        .CC_GOALREGISTER_Data_Out      (data),
        .CC_GOALREGISTER_FrogHome_Out  (home),
        .CC_GOALREGISTER_FrogCrash_Out (crash),
        .CC_GOALREGISTER_LevelUp_Out   (lvlup),
        .CC_GOALREGISTER_Level_Out     (level),
        .CC_GOALREGISTER_Busy_Out      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_row();
        for (int c = 0; c < 8; c++) begin
            arrive = 1'b1;
            col    = 3'(c);
            step();
        end
        arrive = 1'b0;
    endtask

    // Fill the row, ride out the hold, and return the LevelUp seen on the clear.
    task automatic win_level(output logic lu);
        fill_row();
        step();
        for (int t = 0; t < 4; t++) begin
            tick = 1'b1;
            step();
        end
        tick = 1'b0;
        step();
        lu = lvlup;
    endtask

    initial begin
        logic lu;

        #3;
        chk("rst_data", 32'(data), 32'h00);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_level", 32'(level), 32'h0);
        #4 rst_n = 1'b1;
        step();

        arrive = 1'b1; col = 3'd3;
        step();
        arrive = 1'b0;
        chk("c3_data", 32'(data), 32'h08);
        chk("c3_home", 32'(home), 32'h1);
        chk("c3_crash", 32'(crash), 32'h0);
        step();
        chk("c3_home_off", 32'(home), 32'h0);
        arrive = 1'b1; col = 3'd3;
        step();
        arrive = 1'b0;
        chk("c3_crash2", 32'(crash), 32'h1);
        chk("c3_home2", 32'(home), 32'h0);
        chk("c3_data2", 32'(data), 32'h08);
        step();
        chk("c3_crash_off", 32'(crash), 32'h0);

        for (int c = 0; c < 8; c++) begin
            if (c != 3) begin
                arrive = 1'b1;
                col    = 3'(c);
                step();
            end
        end
        arrive = 1'b0;
        chk("fill_data", 32'(data), 32'hFF);
        chk("fill_home", 32'(home), 32'h1);
        chk("fill_busy_early", 32'(busy), 32'h0);
        step();
        chk("hold_busy", 32'(busy), 32'h1);

        arrive = 1'b1; col = 3'd2;
        step();
        chk("hold_c2_home", 32'(home), 32'h0);
        chk("hold_c2_crash", 32'(crash), 32'h0);
        col = 3'd5;
        step();
        arrive = 1'b0;
        chk("hold_c5_home", 32'(home), 32'h0);
        chk("hold_c5_crash", 32'(crash), 32'h0);
        chk("hold_data", 32'(data), 32'hFF);

        for (int t = 0; t < 3; t++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
            chk("hold_tick_busy", 32'(busy), 32'h1);
            chk("hold_tick_lvlup", 32'(lvlup), 32'h0);
        end
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("clr_state_lvlup", 32'(lvlup), 32'h0);
        chk("clr_state_data", 32'(data), 32'hFF);
        step();
        chk("win1_lvlup", 32'(lvlup), 32'h1);
        chk("win1_data", 32'(data), 32'h00);
        chk("win1_level", 32'(level), 32'h1);
        chk("win1_busy", 32'(busy), 32'h0);
        step();
        chk("win1_lvlup_off", 32'(lvlup), 32'h0);

        win_level(lu);
        win_level(lu);
        chk("lvl3", 32'(level), 32'h3);
        fill_row();
        step();
        for (int t = 0; t < 2; t++) begin
            tick = 1'b1;
            step();
        end
        tick = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("nclr_data", 32'(data), 32'h00);
        chk("nclr_level", 32'(level), 32'h0);
        chk("nclr_busy", 32'(busy), 32'h0);
        chk("nclr_lvlup", 32'(lvlup), 32'h0);
        step();
        chk("nclr_lvlup2", 32'(lvlup), 32'h0);
        chk("nclr_busy2", 32'(busy), 32'h0);

        fill_row();
        step();
        chk("rh_busy", 32'(busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rh_data", 32'(data), 32'h00);
        chk("rh_busy0", 32'(busy), 32'h0);
        chk("rh_home", 32'(home), 32'h0);
        chk("rh_crash", 32'(crash), 32'h0);
        chk("rh_lvlup", 32'(lvlup), 32'h0);
        chk("rh_level", 32'(level), 32'h0);
        #3 rst_n = 1'b1;
        step();
        chk("rh_after_busy", 32'(busy), 32'h0);
        arrive = 1'b1; col = 3'd0;
        step();
        arrive = 1'b0;
        chk("rh_accept_data", 32'(data), 32'h01);
        chk("rh_accept_home", 32'(home), 32'h1);

        for (int i = 1; i <= 16; i++) begin
            win_level(lu);
            chk("sat_lvlup", 32'(lu), 32'h1);
            chk("sat_level", 32'(level), (i > 15) ? 32'd15 : 32'(i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
